// File: rtl/mac_ctrl_pkg.sv
// Shared constants, FSM state type and the mask priority helper for the
// zero-skipping MAC layer controller.
package mac_ctrl_pkg;

    localparam int NUM_IN   = 16;
    localparam int BIAS_OFS = 16;
    localparam int DATA_W   = 10;
    localparam int SAT_MAX  = 255;
    localparam int SAT_MIN  = -255;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        BIAS,
        FIN,
        OUT
    } state_t;

    // Index of the highest set bit; the ascending scan lets the last hit win.
    function automatic logic [3:0] msb_index(input logic [NUM_IN-1:0] m);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (m[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sat_add10.sv
// Combinational signed adder with symmetric clamp to [SAT_MIN, SAT_MAX].
// It is shared by the weight and bias accumulate steps.
module sat_add10
    import mac_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum
);

    localparam logic signed [DATA_W:0] SUM_MAX = (DATA_W+1)'(SAT_MAX);
    localparam logic signed [DATA_W:0] SUM_MIN = (DATA_W+1)'(SAT_MIN);

    logic signed [DATA_W:0] raw;

    always_comb begin
        raw = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
        if (raw > SUM_MAX)      sum = SUM_MAX[DATA_W-1:0];
        else if (raw < SUM_MIN) sum = SUM_MIN[DATA_W-1:0];
        else                    sum = raw[DATA_W-1:0];
    end

endmodule

// File: rtl/mac_layer_ctrl.sv
// Sequences sparse weight reads per neuron, accumulates with saturation,
// then adds the bias and presents one result per neuron.
module mac_layer_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter  int NUM_NEURONS = 10,
    parameter  int NEUR_W      = 4,
    localparam int ADDR_W      = NEUR_W + 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_vec,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [9:0]        w_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [9:0]        out_data,
    output logic [NEUR_W-1:0] out_idx,
    output logic              out_last,
    output logic              busy
);

    localparam logic [NEUR_W-1:0] LAST_NEURON = NEUR_W'(NUM_NEURONS - 1);

    state_t              state_q,    state_d;
    logic [NUM_IN-1:0]   mask_q,     mask_d;
    logic [NUM_IN-1:0]   vec_q,      vec_d;
    logic [NEUR_W-1:0]   neuron_q,   neuron_d;
    logic [DATA_W-1:0]   acc_q,      acc_d;
    logic                rd_en_q,    rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q,  rd_addr_d;
    logic                rd_is_w_q,  rd_is_w_d;
    logic                acc_vld_q,  acc_vld_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [NEUR_W-1:0]   out_idx_q,  out_idx_d;
    logic                out_last_q, out_last_d;

    logic [DATA_W-1:0]   sum;
    logic [3:0]          k;

    sat_add10 u_sat (
        .a   (acc_q),
        .b   (w_data),
        .sum (sum)
    );

    assign k = msb_index(mask_q);

    // NOTE: every _d gets its hold value first, so no path through the
    // case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        vec_d      = vec_q;
        neuron_d   = neuron_q;
        acc_d      = acc_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = '0;
        rd_is_w_d  = 1'b0;
        acc_vld_d  = rd_en_q & rd_is_w_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        out_last_d = out_last_q;

        // Weight data lands one cycle after its registered read strobe.
        if (acc_vld_q) acc_d = sum;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    vec_d    = in_vec;
                    mask_d   = in_vec;
                    neuron_d = '0;
                    acc_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                rd_en_d = 1'b1;
                if (mask_q != '0) begin
                    rd_addr_d = {neuron_q, 1'b0, k};
                    rd_is_w_d = 1'b1;
                    mask_d    = mask_q & ~(NUM_IN'(1) << k);
                end else begin
                    rd_addr_d = {neuron_q, 5'(BIAS_OFS)};
                    state_d   = BIAS;
                end
            end
            BIAS: begin
                state_d = FIN;
            end
            FIN: begin
                acc_d      = sum;
                out_data_d = sum;
                out_idx_d  = neuron_q;
                out_last_d = (neuron_q == LAST_NEURON);
                state_d    = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    out_last_d = 1'b0;
                    if (neuron_q == LAST_NEURON) begin
                        state_d = IDLE;
                    end else begin
                        neuron_d = neuron_q + 1'b1;
                        mask_d   = vec_q;
                        acc_d    = '0;
                        state_d  = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignment so every flop samples
    // pre-edge values; clearing acc_vld on reset drops in-flight read data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            vec_q      <= '0;
            neuron_q   <= '0;
            acc_q      <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_is_w_q  <= 1'b0;
            acc_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            vec_q      <= vec_d;
            neuron_q   <= neuron_d;
            acc_q      <= acc_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            rd_is_w_q  <= rd_is_w_d;
            acc_vld_q  <= acc_vld_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
            out_last_q <= out_last_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && reset;
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == OUT);
    assign w_rd_en   = rd_en_q;
    assign w_addr    = rd_addr_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_mac_layer_ctrl.sv
// Directed bench for mac_layer_ctrl: a two-neuron instance for the main
// scenarios and a single-neuron instance for the bias-only case.
module tb_mac_layer_ctrl;

    localparam int NEUR_W = 4;
    localparam int ADDR_W = NEUR_W + 5;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // two-neuron instance
    logic              in_valid = 1'b0, in_ready;
    logic [15:0]       in_vec = '0;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_addr;
    logic [9:0]        w_data = '0;
    logic              out_valid, out_ready = 1'b0, out_last, busy;
    logic [9:0]        out_data;
    logic [NEUR_W-1:0] out_idx;

    // single-neuron instance
    logic              in_valid1 = 1'b0, in_ready1;
    logic [15:0]       in_vec1 = '0;
    logic              w_rd_en1;
    logic [ADDR_W-1:0] w_addr1;
    logic [9:0]        w_data1 = '0;
    logic              out_valid1, out_ready1 = 1'b0, out_last1, busy1;
    logic [9:0]        out_data1;
    logic [NEUR_W-1:0] out_idx1;

    mac_layer_ctrl #(.NUM_NEURONS(2), .NEUR_W(NEUR_W)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    mac_layer_ctrl #(.NUM_NEURONS(1), .NEUR_W(NEUR_W)) u_dut1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_vec(in_vec1),
        .w_rd_en(w_rd_en1), .w_addr(w_addr1), .w_data(w_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .out_idx(out_idx1), .out_last(out_last1), .busy(busy1)
    );

    // Weight memory: one-cycle read latency, junk on the bus when not read.
    logic [9:0] mem [0:511];
    int rd_log[$];
    int rd_log1[$];
    int exp_rd[$];

    always @(posedge clk) begin
        w_data  <= w_rd_en  ? mem[w_addr]  : 10'h2AA;
        w_data1 <= w_rd_en1 ? mem[w_addr1] : 10'h2AA;
        if (reset && w_rd_en)  rd_log.push_back(int'(w_addr));
        if (reset && w_rd_en1) rd_log1.push_back(int'(w_addr1));
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = '0;
    endtask

    task automatic set_w(input int addr, input int val);
        mem[addr] = 10'(val);
    endtask

    task automatic check_reads(input string tag);
        check({tag, ".nrd"}, rd_log.size(), exp_rd.size());
        for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
            check($sformatf("%s.rd%0d", tag, i), rd_log[i], exp_rd[i]);
        rd_log.delete();
    endtask

    task automatic do_input(input string tag, input logic [15:0] vec);
        @(negedge clk);
        check({tag, ".in_ready"}, int'(in_ready), 1);
        in_vec   = vec;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits for a result, checks it, optionally stalls (poking in_valid while
    // busy), then completes the handshake.
    task automatic get_out(input string tag, input int exp_data, input int exp_idx,
                           input int exp_last, input int exp_lat, input int stall);
        int lat;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        check({tag, ".lat"}, lat, exp_lat);
        if (lat < 0) return;
        check({tag, ".data"}, int'($signed(out_data)), exp_data);
        check({tag, ".idx"}, int'(out_idx), exp_idx);
        check({tag, ".last"}, int'(out_last), exp_last);
        check({tag, ".in_ready_busy"}, int'(in_ready), 0);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_vec   = 16'hFFFF;
            @(posedge clk);
            #1;
            check($sformatf("%s.stall%0d.valid", tag, s), int'(out_valid), 1);
            check($sformatf("%s.stall%0d.data", tag, s), int'($signed(out_data)), exp_data);
            check($sformatf("%s.stall%0d.idx", tag, s), int'(out_idx), exp_idx);
            check($sformatf("%s.stall%0d.last", tag, s), int'(out_last), exp_last);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [15:0] vec, input int p,
                           input int e0, input int e1, input int stall0);
        do_input(tag, vec);
        get_out({tag, ".n0"}, e0, 0, 0, p + 3, stall0);
        get_out({tag, ".n1"}, e1, 1, 1, p + 3, 0);
        check({tag, ".in_ready_after"}, int'(in_ready), 1);
        check({tag, ".busy_after"}, int'(busy), 0);
        check_reads(tag);
    endtask

    initial begin
        int lat;
        clear_mem();
        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready_low", int'(in_ready), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst.in_ready", int'(in_ready), 1);
        check("rst.busy", int'(busy), 0);
        check("rst.out_valid", int'(out_valid), 0);
        check("rst.w_rd_en", int'(w_rd_en), 0);
        check("rst.out_data", int'(out_data), 0);

        // Two reads plus bias; out_ready stalled 3 cycles on neuron 0.
        clear_mem();
        set_w(15, 100); set_w(0, -30); set_w(16, -10);
        set_w(47, 10);  set_w(32, 20); set_w(48, 3);
        exp_rd = {15, 0, 16, 47, 32, 48};
        run_vec("a", 16'h8001, 2, 60, 33, 3);

        // Upper clamp mid-sequence; neuron 1 mirrors it negatively.
        clear_mem();
        set_w(2, 200);   set_w(1, 200);   set_w(0, -100); set_w(16, 0);
        set_w(34, -200); set_w(33, -200); set_w(32, 100); set_w(48, 0);
        exp_rd = {2, 1, 0, 16, 34, 33, 32, 48};
        run_vec("b", 16'h0007, 3, 155, -155, 0);

        // Lower clamp at each step; neuron 1 hits the -256 corner.
        clear_mem();
        set_w(1, -200);  set_w(0, -200); set_w(16, -50);
        set_w(33, -255); set_w(32, -1);  set_w(48, 0);
        exp_rd = {1, 0, 16, 33, 32, 48};
        run_vec("c", 16'h0003, 2, -255, -255, 0);

        // Empty input vector: bias reads only.
        clear_mem();
        set_w(16, 7); set_w(48, -8);
        exp_rd = {16, 48};
        run_vec("d", 16'h0000, 0, 7, -8, 0);

        // Single-neuron instance, bias only.
        clear_mem();
        set_w(16, 5);
        @(negedge clk);
        in_vec1   = 16'h0000;
        in_valid1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (out_valid1) begin
                lat = n;
                break;
            end
        end
        check("e.lat", lat, 3);
        check("e.data", int'($signed(out_data1)), 5);
        check("e.idx", int'(out_idx1), 0);
        check("e.last", int'(out_last1), 1);
        out_ready1 = 1'b1;
        @(posedge clk);
        #1;
        out_ready1 = 1'b0;
        check("e.in_ready_after", int'(in_ready1), 1);
        check("e.nrd", rd_log1.size(), 1);
        if (rd_log1.size() > 0) check("e.rd0", rd_log1[0], 16);

        // Reset held two cycles in the middle of a full-mask run.
        clear_mem();
        for (int i = 0; i < 16; i++) set_w(i, 1);
        do_input("f", 16'hFFFF);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("f.in_ready_in_reset", int'(in_ready), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("f.in_ready", int'(in_ready), 1);
        check("f.busy", int'(busy), 0);
        check("f.out_valid", int'(out_valid), 0);
        check("f.w_rd_en", int'(w_rd_en), 0);
        check("f.w_addr", int'(w_addr), 0);
        check("f.out_data", int'(out_data), 0);
        check("f.out_idx", int'(out_idx), 0);
        check("f.out_last", int'(out_last), 0);
        rd_log.delete();

        // Fresh transaction after the abort must start from a clean accumulator.
        clear_mem();
        set_w(0, 50);  set_w(16, -5);
        set_w(32, -7); set_w(48, 2);
        exp_rd = {0, 16, 32, 48};
        run_vec("g", 16'h0001, 1, 45, -5, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
